// File: rtl/write_sequencer_pkg.sv
// Shared SRAM write-path constants, default geometry and sequencer state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sram_pkg;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    localparam int COLS_DEF   = 8;
    localparam int ROWS_DEF   = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DRIVE,
        WLON,
        HOLD
    } state_t;

    // Width of a down-counter that must hold (longest duration - 1); never below one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/write_sequencer_if.sv
// Request handshake plus array-side drive signals of the write sequencer.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready handshake; the array side has no backpressure.
interface write_sequencer_if
    import sram_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [COLS-1:0]   req_data;
    real               data_out [0:0][0:COLS-1];
    logic              drv_en;
    logic              pre_en;
    real               wl [0:ROWS-1];
    logic              done;
    logic              addr_err;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, data_out, drv_en, pre_en, wl, done, addr_err
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, data_out, drv_en, pre_en, wl, done, addr_err
    );
endinterface

// File: rtl/write_sequencer_wl_decoder.sv
// Row address to one-hot word-line voltages (VDD on the selected row, VSS elsewhere).
// Latency: combinational.
// Backpressure: none; all lines sit at VSS while en is low.
module wl_decoder
    import sram_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output real               wl [0:ROWS-1]
);

    // Raise exactly the addressed line when enabled; rows past ROWS can never be selected.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            wl[r] = VSS;
            if (en && (addr == ADDR_W'(r))) begin
                wl[r] = VDD;
            end
        end
    end

endmodule

// File: rtl/write_sequencer.sv
// SRAM row write sequencer: precharge, data setup, word-line pulse, then done.
// Latency: done is high PRE_CYC+WL_CYC+2 cycles after the accepting edge; ready one cycle later.
// Backpressure: req_ready only in IDLE; requests outside IDLE are ignored, never queued.
module write_sequencer
    import sram_pkg::*;
#(
    parameter int COLS    = COLS_DEF,
    parameter int ROWS    = ROWS_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 3
) (
    input logic               clk,
    input logic               rst,
    write_sequencer_if.slave  bus
);

    localparam int CNT_W = cnt_width(PRE_CYC, WL_CYC);
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYC - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [COLS-1:0]   data_q;
    logic              ready_q;
    logic              err_q;
    logic              accept;
    logic              in_range;
    logic              wl_on;
    logic              drv_phase;
    real               wl_int [0:ROWS-1];

    assign accept   = bus.req_valid & ready_q;
    assign in_range = (32'(bus.req_addr) < ROWS);

    // Next state and counter reload on every state entry; array controls decode from registered state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wl_on     = 1'b0;
        drv_phase = 1'b0;
        bus.pre_en = 1'b0;
        bus.drv_en = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && in_range) begin
                    state_nxt = PRE;
                    cnt_nxt   = PRE_LOAD;
                end
            end
            PRE: begin
                bus.pre_en = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DRIVE: begin
                bus.drv_en = 1'b1;
                drv_phase  = 1'b1;
                state_nxt  = WLON;
                cnt_nxt    = WL_LOAD;
            end
            WLON: begin
                bus.drv_en = 1'b1;
                drv_phase  = 1'b1;
                wl_on      = 1'b1;
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                bus.drv_en = 1'b1;
                bus.done   = 1'b1;
                drv_phase  = 1'b1;
                state_nxt  = IDLE;
                cnt_nxt    = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter, handshake latches and the registered ready/error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ready_q <= (state_nxt == IDLE);
            err_q   <= accept & ~in_range;
            if (accept) begin
                addr_q <= bus.req_addr;
                data_q <= bus.req_data;
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.addr_err  = err_q;

    wl_decoder #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_wl_decoder (
        .en   (wl_on),
        .addr (addr_q),
        .wl   (wl_int)
    );

    // Forward decoded word lines to the array port.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            bus.wl[r] = wl_int[r];
        end
    end

    // Data levels follow the latched word from DRIVE through HOLD, VSS otherwise.
    always_comb begin
        for (int i = 0; i < COLS; i++) begin
            bus.data_out[0][i] = (drv_phase && data_q[i]) ? VDD : VSS;
        end
    end

endmodule

// File: tb/tb_write_sequencer.sv
// Randomized bench for two sequencer instances (PRE/WL = 2/3 and 1/1) against a timeline model.
// Latency: n/a.
// Backpressure: requests held on req_valid until the model sees them accepted.
module tb_write_sequencer;
    import sram_pkg::*;

    localparam int COLS   = 8;
    localparam int ROWS   = 12;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    write_sequencer_if #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) bus0 ();
    write_sequencer_if #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) bus1 ();

    write_sequencer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .PRE_CYC(2), .WL_CYC(3))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    write_sequencer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .PRE_CYC(1), .WL_CYC(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // stimulus
    logic              vld [2];
    logic [ADDR_W-1:0] ia  [2];
    logic [COLS-1:0]   id  [2];
    bit                from_q [2];
    bit                noise;
    bit                pulse [2];
    logic [ADDR_W-1:0] fa [2][16];
    logic [COLS-1:0]   fd [2][16];
    int                fh [2];
    int                ft [2];

    assign bus0.req_valid = vld[0];
    assign bus0.req_addr  = ia[0];
    assign bus0.req_data  = id[0];
    assign bus1.req_valid = vld[1];
    assign bus1.req_addr  = ia[1];
    assign bus1.req_data  = id[1];

    // reference model: timeline position d of the current write (d=1 on the cycle after acceptance)
    bit              m_act [2];
    int              m_d   [2];
    logic [ADDR_W-1:0] m_a [2];
    logic [COLS-1:0] m_dat [2];
    bit              m_err [2];
    int              acc_cyc [2];
    int              last_done [2];
    bit              gap_chk;
    int              cyc;

    // observed
    logic            o_rdy [2], o_pre [2], o_drv [2], o_done [2], o_err [2], o_done_prev [2];
    logic [ROWS-1:0] o_wl [2];
    logic [COLS-1:0] o_dat [2];
    int              o_bad [2];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pre_of(input int p);
        return (p == 0) ? 2 : 1;
    endfunction

    function automatic int wlc_of(input int p);
        return (p == 0) ? 3 : 1;
    endfunction

    task automatic push(input int p, input logic [ADDR_W-1:0] a, input logic [COLS-1:0] d);
        fa[p][ft[p]] = a;
        fd[p][ft[p]] = d;
        ft[p]++;
    endtask

    task automatic drive_next();
        for (int p = 0; p < 2; p++) begin
            from_q[p] = 1'b0;
            if (pulse[p]) begin
                vld[p] = 1'b1; ia[p] = 4'd7; id[p] = 8'hFF;
            end else if (fh[p] < ft[p]) begin
                vld[p] = 1'b1; ia[p] = fa[p][fh[p]]; id[p] = fd[p][fh[p]];
                from_q[p] = 1'b1;
            end else if (noise) begin
                vld[p] = 1'($urandom_range(0, 1));
                ia[p]  = ADDR_W'($urandom_range(0, 15));
                id[p]  = COLS'($urandom);
            end else begin
                vld[p] = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_act[p] = 1'b0; m_d[p] = 0; m_err[p] = 1'b0;
            fh[p] = 0; ft[p] = 0; pulse[p] = 1'b0;
            last_done[p] = -1;
        end
    endtask

    task automatic model_edge();
        for (int p = 0; p < 2; p++) begin
            int tot;
            tot = pre_of(p) + wlc_of(p) + 2;
            m_err[p] = 1'b0;
            if (m_act[p]) begin
                m_d[p]++;
                if (m_d[p] > tot) m_act[p] = 1'b0;
            end else if (vld[p]) begin
                if (int'(ia[p]) >= ROWS) begin
                    m_err[p] = 1'b1;
                end else begin
                    m_act[p] = 1'b1; m_d[p] = 1;
                    m_a[p] = ia[p]; m_dat[p] = id[p];
                    acc_cyc[p] = cyc;
                end
                if (from_q[p]) fh[p]++;
            end
        end
    endtask

    task automatic sample();
        o_rdy[0] = bus0.req_ready; o_pre[0] = bus0.pre_en; o_drv[0] = bus0.drv_en;
        o_done[0] = bus0.done; o_err[0] = bus0.addr_err;
        o_rdy[1] = bus1.req_ready; o_pre[1] = bus1.pre_en; o_drv[1] = bus1.drv_en;
        o_done[1] = bus1.done; o_err[1] = bus1.addr_err;
        for (int p = 0; p < 2; p++) begin
            o_wl[p] = '0; o_dat[p] = '0; o_bad[p] = 0;
        end
        for (int r = 0; r < ROWS; r++) begin
            if (bus0.wl[r] == VDD) o_wl[0][r] = 1'b1; else if (bus0.wl[r] != VSS) o_bad[0]++;
            if (bus1.wl[r] == VDD) o_wl[1][r] = 1'b1; else if (bus1.wl[r] != VSS) o_bad[1]++;
        end
        for (int i = 0; i < COLS; i++) begin
            if (bus0.data_out[0][i] == VDD) o_dat[0][i] = 1'b1; else if (bus0.data_out[0][i] != VSS) o_bad[0]++;
            if (bus1.data_out[0][i] == VDD) o_dat[1][i] = 1'b1; else if (bus1.data_out[0][i] != VSS) o_bad[1]++;
        end
    endtask

    task automatic check_outputs();
        for (int p = 0; p < 2; p++) begin
            int pre, wlc;
            logic e_pre, e_drv, e_wlon, e_done;
            logic [ROWS-1:0] e_wl;
            logic [COLS-1:0] e_dat;
            pre = pre_of(p); wlc = wlc_of(p);
            e_pre  = m_act[p] && (m_d[p] <= pre);
            e_drv  = m_act[p] && (m_d[p] > pre);
            e_wlon = m_act[p] && (m_d[p] >= pre + 2) && (m_d[p] <= pre + wlc + 1);
            e_done = m_act[p] && (m_d[p] == pre + wlc + 2);
            e_wl = '0;
            if (e_wlon) e_wl[m_a[p]] = 1'b1;
            e_dat = e_drv ? m_dat[p] : '0;
            chk($sformatf("ready%0d", p), o_rdy[p], !m_act[p]);
            chk($sformatf("pre_en%0d", p), o_pre[p], e_pre);
            chk($sformatf("drv_en%0d", p), o_drv[p], e_drv);
            chk($sformatf("done%0d", p), o_done[p], e_done);
            chk($sformatf("addr_err%0d", p), o_err[p], m_err[p]);
            chk($sformatf("wl%0d", p), 32'(o_wl[p]), 32'(e_wl));
            chk($sformatf("data_out%0d", p), 32'(o_dat[p]), 32'(e_dat));
            chk($sformatf("levels%0d", p), o_bad[p], 0);
            chk($sformatf("wl_excl%0d", p),
                ($countones(o_wl[p]) <= 1) && !(o_pre[p] && (o_wl[p] != '0)), 1'b1);
            if (o_done[p] && !o_done_prev[p]) begin
                chk($sformatf("latency%0d", p), cyc - acc_cyc[p], (p == 0) ? 6 : 3);
                if (gap_chk && last_done[p] >= 0)
                    chk($sformatf("b2b_gap%0d", p), cyc - last_done[p], (p == 0) ? 8 : 5);
                last_done[p] = cyc;
            end
            o_done_prev[p] = o_done[p];
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        sample();
        check_outputs();
        drive_next();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int guard;
        cyc = 0; noise = 1'b0; gap_chk = 1'b0;
        for (int p = 0; p < 2; p++) begin
            vld[p] = 1'b0; ia[p] = '0; id[p] = '0; from_q[p] = 1'b0;
            acc_cyc[p] = 0; m_a[p] = '0; m_dat[p] = '0; o_done_prev[p] = 1'b0;
        end
        model_reset();

        // reset state, then a request on the very first edge after release
        @(negedge clk);
        sample();
        check_outputs();
        rst = 1'b0;
        push(0, 4'd5, 8'hA5);
        push(1, 4'd5, 8'hA5);
        drive_next();
        run(12);

        // out-of-range row
        push(0, 4'd13, 8'h3C);
        push(1, 4'd13, 8'h3C);
        drive_next();
        run(4);

        // back-to-back rows 1 then 2
        for (int p = 0; p < 2; p++) begin
            fh[p] = 0; ft[p] = 0; last_done[p] = -1;
            push(p, 4'd1, 8'h0F);
            push(p, 4'd2, 8'hF0);
        end
        gap_chk = 1'b1;
        drive_next();
        run(22);
        gap_chk = 1'b0;

        // request pulse during WLON is ignored
        fh[0] = 0; ft[0] = 0;
        push(0, 4'd3, 8'h81);
        drive_next();
        guard = 0;
        while (!(m_act[0] && m_d[0] == 4) && guard < 20) begin step(); guard++; end
        if (guard >= 20) chk("wlon_wait", 0, 1);
        pulse[0] = 1'b1;
        drive_next();
        step();
        pulse[0] = 1'b0;
        drive_next();
        run(12);

        // asynchronous reset in the middle of WLON
        for (int p = 0; p < 2; p++) begin
            fh[p] = 0; ft[p] = 0;
            push(p, 4'd9, 8'hC3);
        end
        drive_next();
        guard = 0;
        while (!(m_act[0] && m_d[0] == 5) && guard < 20) begin step(); guard++; end
        if (guard >= 20) chk("wlon_wait2", 0, 1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        sample();
        check_outputs();
        #2 rst = 1'b0;
        push(0, 4'd4, 8'h5A);
        push(1, 4'd4, 8'h5A);
        drive_next();
        run(12);

        // random traffic, including out-of-range rows and requests while busy
        noise = 1'b1;
        run(400);
        noise = 1'b0;
        drive_next();
        run(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
